regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between the primary writeback result (destination register `rt` from writeback) and the base-register update produced by pre/post-indexed loads and stores with writeback (`W` set). Losing requests are held in a small in-order FIFO and drained ahead of newer traffic. The block sits between the writeback pipeline unit and the register file. It also gives the decode stage a hazard check against writes that have not yet landed.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO entries; legal range 2..8.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  primary writeback request.
- `a_addr`  in  4  destination register number.
- `a_data`  in  32  result value.
- `b_valid`  in  1  base-update request.
- `b_addr`  in  4  base register (`rn`).
- `b_data`  in  32  updated base address.
- `w_en`  out  1  register-file write enable, registered.
- `w_addr`  out  4  write register number, registered.
- `w_data`  out  32  write data, registered.
- `stall`  out  1  registered; upstream must hold new requests.
- `ovf`  out  1  sticky error flag; a request arrived while `stall`=1.
- `chk_addr`  in  4  register number being read by decode.
- `chk_hit`  out  1  combinational; `chk_addr` matches a pending or in-flight write.

## Operation
- Candidate sources, in priority order each cycle:
  1. FIFO head (oldest).
  2. A.
  3. B.
- Exactly one candidate is granted per cycle, when any exists.
- Every valid request that is not granted is pushed into the FIFO in the same cycle. If both A and B are pushed, A goes first. The FIFO can take 0, 1 or 2 pushes per cycle.
- Resulting order: program order is preserved. When A and B target the same register in the same cycle, A is written first and then B, so B's value persists.
- Granted request → `w_en`=1, `w_addr`/`w_data` = the winner's values, all on the next edge. No grant → `w_en`=0; `w_addr`/`w_data` hold their previous values.
- `count` = FIFO occupancy. Read and write pointers wrap modulo `DEPTH`.
- `stall` is registered: it is high for the next cycle when the post-update `count` > `DEPTH`−2, i.e. fewer than 2 free slots.
- Requests presented while `stall`=1:
  - They are not accepted, granted or pushed.
  - They set `ovf`, which is cleared only by reset.
  - Buffered entries keep draining, one per cycle.
- `chk_hit` is 1 when any valid FIFO entry, or the `w_*` register with `w_en`=1, has an address equal to `chk_addr`.
- Register 15 is not special-cased; it is arbitrated like any other register.

## Timing
- Reset (asynchronous, while `rst_n`=0): `w_en`=0, `w_addr`=0, `w_data`=0, `stall`=0, `ovf`=0, `count`=0, pointers=0.
- Reset mid-operation: all buffered writes are discarded, and no write is issued on the edge that follows reset release.
- Latency:
  - Lone request with FIFO empty: 1 cycle to `w_en`.
  - Buffered request: 1 cycle plus its FIFO position.
- Simultaneous A+B with FIFO empty: A is written at cycle t+1 and B at t+2; `count` is 1 during t+1.
- With `DEPTH`=2, that single buffered entry raises `stall` for cycle t+1. `stall` falls on the edge where `count` returns to 0.
- FIFO full (`count`=`DEPTH`) cannot be reached with a compliant upstream. Reaching it is a design error; no push beyond `DEPTH` ever occurs.
- `chk_hit` is purely combinational from `chk_addr` and the current state, with no added cycle.

## Configuration
- `WB_ARB_HAZARD_EN` defined: the `chk_hit` comparator logic is built as described above.
- `WB_ARB_HAZARD_EN` undefined: the `chk_addr` port remains, `chk_hit` is tied to 0, and no comparators are synthesized.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert `rst_n`=0 mid-burst with `count`=1 → all outputs 0 immediately; after release, no write appears even though a request was buffered.
- Lone A: `a_valid`=1, `a_addr`=3, `a_data`=0x1234 at t → at t+1 `w_en`=1, `w_addr`=3, `w_data`=0x1234; at t+2 `w_en`=0.
- Collision: A(r5, 0xAAAA) and B(r5, 0xBBBB) at t, `DEPTH`=2 →
  - t+1: write r5=0xAAAA, `stall`=1.
  - t+2: write r5=0xBBBB.
  - t+3: `stall`=0.
- Violation: a request presented while `stall`=1 → it is dropped, `ovf`=1 until reset, and the buffered entry is still written.
- Ordering: `DEPTH`=4; A+B together, then A alone the next cycle → writes occur in order A0, B0, A1 on consecutive cycles.
- Hazard (with `WB_ARB_HAZARD_EN`): B(r2) is buffered and `chk_addr`=2 → `chk_hit`=1; once drained, `chk_hit`=0. Without the macro, `chk_hit` stays 0 throughout.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: FIFO head, then writeback A, then base update B.
// Optional hazard comparator built only when WB_ARB_HAZARD_EN is defined.
module regfile_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [3:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [3:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        w_en,
    output logic [3:0]  w_addr,
    output logic [31:0] w_data,
    output logic        stall,
    output logic        ovf,
    input  logic [3:0]  chk_addr,
    output logic        chk_hit
);

    logic [3:0]  fifo_addr_q [8];
    logic [31:0] fifo_data_q [8];
    logic [3:0]  fifo_addr_d [8];
    logic [31:0] fifo_data_d [8];
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        w_en_q, w_en_d;
    logic [3:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic        stall_q, stall_d;
    logic        ovf_q, ovf_d;

    function automatic logic [2:0] inc(input logic [2:0] p);
        return (p == 3'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // Grant selection, FIFO push/pop and next-state for all registers
    always_comb begin
        logic        a_acc, b_acc, pop, gnt_v, push_a, push_b;
        logic [3:0]  gnt_addr, free;
        logic [31:0] gnt_data;
        logic [2:0]  wp;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        a_acc    = a_valid && !stall_q;
        b_acc    = b_valid && !stall_q;
        pop      = (count_q != 4'd0);
        gnt_v    = 1'b1;
        gnt_addr = fifo_addr_q[rd_ptr_q];
        gnt_data = fifo_data_q[rd_ptr_q];
        push_a   = 1'b0;
        push_b   = 1'b0;
        if (pop) begin
            push_a = a_acc;
            push_b = b_acc;
        end else if (a_acc) begin
            gnt_addr = a_addr;
            gnt_data = a_data;
            push_b   = b_acc;
        end else if (b_acc) begin
            gnt_addr = b_addr;
            gnt_data = b_data;
        end else begin
            gnt_v = 1'b0;
        end
        // never write past DEPTH even if upstream misbehaves
        free = 4'(DEPTH) - count_q + {3'd0, pop};
        if (push_a && free == 4'd0)
            push_a = 1'b0;
        if (push_b && ({3'd0, push_a} + 4'd1) > free)
            push_b = 1'b0;
        wp = wr_ptr_q;
        if (push_a) begin
            fifo_addr_d[wp] = a_addr;
            fifo_data_d[wp] = a_data;
            wp = inc(wp);
        end
        if (push_b) begin
            fifo_addr_d[wp] = b_addr;
            fifo_data_d[wp] = b_data;
            wp = inc(wp);
        end
        wr_ptr_d = wp;
        rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q - {3'd0, pop} + {3'd0, push_a} + {3'd0, push_b};
        stall_d  = count_d > 4'(DEPTH - 2);
        ovf_d    = ovf_q | (stall_q & (a_valid | b_valid));
        w_en_d   = gnt_v;
        w_addr_d = gnt_v ? gnt_addr : w_addr_q;
        w_data_d = gnt_v ? gnt_data : w_data_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            stall_q     <= stall_d;
            ovf_q       <= ovf_d;
        end
    end

    assign w_en   = w_en_q;
    assign w_addr = w_addr_q;
    assign w_data = w_data_q;
    assign stall  = stall_q;
    assign ovf    = ovf_q;

`ifdef WB_ARB_HAZARD_EN
    // Match decode's register against buffered entries and the in-flight write
    always_comb begin
        logic [3:0] idx;
        chk_hit = w_en_q && (w_addr_q == chk_addr);
        for (int k = 0; k < DEPTH; k++) begin
            idx = {1'b0, rd_ptr_q} + 4'(k);
            if (idx >= 4'(DEPTH))
                idx = idx - 4'(DEPTH);
            if (4'(k) < count_q && fifo_addr_q[idx[2:0]] == chk_addr)
                chk_hit = 1'b1;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^chk_addr;
    assign chk_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with DEPTH=2 and DEPTH=4 instances.
// Expected writes are queued per instance and popped as w_en appears.
module tb_regfile_write_arbiter;

`ifdef WB_ARB_HAZARD_EN
    localparam logic HZ = 1'b1;
`else
    localparam logic HZ = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        sel = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0]  a_addr = '0, b_addr = '0, chk_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;

    logic        av2, bv2, av4, bv4;
    assign av2 = a_valid & ~sel;
    assign bv2 = b_valid & ~sel;
    assign av4 = a_valid & sel;
    assign bv4 = b_valid & sel;

    logic        w_en2, stall2, ovf2, hit2;
    logic [3:0]  w_addr2;
    logic [31:0] w_data2;
    logic        w_en4, stall4, ovf4, hit4;
    logic [3:0]  w_addr4;
    logic [31:0] w_data4;

    regfile_write_arbiter #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(av2), .a_addr(a_addr), .a_data(a_data),
        .b_valid(bv2), .b_addr(b_addr), .b_data(b_data),
        .w_en(w_en2), .w_addr(w_addr2), .w_data(w_data2),
        .stall(stall2), .ovf(ovf2),
        .chk_addr(chk_addr), .chk_hit(hit2)
    );

    regfile_write_arbiter #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(av4), .a_addr(a_addr), .a_data(a_data),
        .b_valid(bv4), .b_addr(b_addr), .b_data(b_data),
        .w_en(w_en4), .w_addr(w_addr4), .w_data(w_data4),
        .stall(stall4), .ovf(ovf4),
        .chk_addr(chk_addr), .chk_hit(hit4)
    );

    int checks = 0;
    int errors = 0;
    logic [35:0] q2[$];
    logic [35:0] q4[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic av, input logic [3:0] aa,
                       input logic [31:0] ad, input logic bv,
                       input logic [3:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    // Scoreboard: every write must match the oldest expected entry
    always @(negedge clk) begin
        logic [35:0] e;
        if (rst_n && w_en2) begin
            if (q2.size() == 0) begin
                chk("d2_unexpected_write", 32'(w_addr2), 32'hffff_ffff);
            end else begin
                e = q2.pop_front();
                chk("d2_w_addr", 32'(w_addr2), 32'(e[35:32]));
                chk("d2_w_data", w_data2, e[31:0]);
            end
        end
        if (rst_n && w_en4) begin
            if (q4.size() == 0) begin
                chk("d4_unexpected_write", 32'(w_addr4), 32'hffff_ffff);
            end else begin
                e = q4.pop_front();
                chk("d4_w_addr", 32'(w_addr4), 32'(e[35:32]));
                chk("d4_w_data", w_data4, e[31:0]);
            end
        end
    end

    initial begin
        // power-on reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst_w_en2", 32'(w_en2), 0);
        chk("rst_w_addr2", 32'(w_addr2), 0);
        chk("rst_w_data2", w_data2, 0);
        chk("rst_stall2", 32'(stall2), 0);
        chk("rst_ovf2", 32'(ovf2), 0);
        chk("rst_hit2", 32'(hit2), 0);
        chk("rst_w_en4", 32'(w_en4), 0);
        chk("rst_stall4", 32'(stall4), 0);
        #19 rst_n = 1'b1;

        // lone A
        tick();
        set(1, 4'd3, 32'h1234, 0, 4'd0, 0);
        q2.push_back({4'd3, 32'h1234});
        tick();
        set(0, 0, 0, 0, 0, 0);
        chk("loneA_w_en", 32'(w_en2), 1);
        chk("loneA_w_addr", 32'(w_addr2), 3);
        chk("loneA_w_data", w_data2, 32'h1234);
        tick();
        chk("loneA_w_en_off", 32'(w_en2), 0);

        // collision on r5, DEPTH=2
        chk_addr = 4'd5;
        tick();
        set(1, 4'd5, 32'hAAAA, 1, 4'd5, 32'hBBBB);
        q2.push_back({4'd5, 32'hAAAA});
        q2.push_back({4'd5, 32'hBBBB});
        tick();
        set(0, 0, 0, 0, 0, 0);
        chk("coll_t1_data", w_data2, 32'hAAAA);
        chk("coll_t1_stall", 32'(stall2), 1);
        chk("coll_t1_hit", 32'(hit2), 32'(HZ));
        tick();
        chk("coll_t2_w_en", 32'(w_en2), 1);
        chk("coll_t2_data", w_data2, 32'hBBBB);
        tick();
        chk("coll_t3_stall", 32'(stall2), 0);
        chk("coll_t3_w_en", 32'(w_en2), 0);
        chk("coll_t3_hit", 32'(hit2), 0);

        // request while stalled is dropped and flagged
        tick();
        set(1, 4'd7, 32'h77, 1, 4'd8, 32'h88);
        q2.push_back({4'd7, 32'h77});
        q2.push_back({4'd8, 32'h88});
        tick();
        set(1, 4'd9, 32'h99, 0, 0, 0);
        chk("viol_stall", 32'(stall2), 1);
        chk("viol_ovf_pre", 32'(ovf2), 0);
        tick();
        set(0, 0, 0, 0, 0, 0);
        chk("viol_drain_addr", 32'(w_addr2), 8);
        chk("viol_ovf", 32'(ovf2), 1);
        tick();
        chk("viol_w_en_off", 32'(w_en2), 0);
        chk("viol_ovf_sticky", 32'(ovf2), 1);
        chk("viol_stall_off", 32'(stall2), 0);

        // hazard on buffered B(r2)
        chk_addr = 4'd2;
        tick();
        set(1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
        q2.push_back({4'd1, 32'h11});
        q2.push_back({4'd2, 32'h22});
        tick();
        set(0, 0, 0, 0, 0, 0);
        chk("hz_buffered", 32'(hit2), 32'(HZ));
        tick();
        chk("hz_inflight", 32'(hit2), 32'(HZ));
        tick();
        chk("hz_drained", 32'(hit2), 0);

        // ordering A0,B0,A1 with DEPTH=4
        sel = 1'b1;
        tick();
        set(1, 4'd1, 32'hA0, 1, 4'd2, 32'hB0);
        q4.push_back({4'd1, 32'hA0});
        q4.push_back({4'd2, 32'hB0});
        tick();
        set(1, 4'd3, 32'hA1, 0, 0, 0);
        q4.push_back({4'd3, 32'hA1});
        chk("ord_A0_addr", 32'(w_addr4), 1);
        chk("ord_stall4", 32'(stall4), 0);
        tick();
        set(0, 0, 0, 0, 0, 0);
        chk("ord_B0_data", w_data4, 32'hB0);
        tick();
        chk("ord_A1_data", w_data4, 32'hA1);
        chk("ord_A1_w_en", 32'(w_en4), 1);
        tick();
        chk("ord_idle", 32'(w_en4), 0);
        sel = 1'b0;

        // reset mid-burst with one entry buffered
        tick();
        set(1, 4'd4, 32'h44, 1, 4'd6, 32'h66);
        q2.push_back({4'd4, 32'h44});
        tick();
        set(0, 0, 0, 0, 0, 0);
        chk("mid_stall", 32'(stall2), 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        chk_addr = 4'd6;
        #1;
        chk("mid_rst_w_en", 32'(w_en2), 0);
        chk("mid_rst_w_addr", 32'(w_addr2), 0);
        chk("mid_rst_w_data", w_data2, 0);
        chk("mid_rst_stall", 32'(stall2), 0);
        chk("mid_rst_ovf", 32'(ovf2), 0);
        chk("mid_rst_hit", 32'(hit2), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_w_en_1", 32'(w_en2), 0);
        tick();
        chk("post_rst_w_en_2", 32'(w_en2), 0);
        chk("post_rst_hit", 32'(hit2), 0);

        tick();
        chk("q2_empty", 32'(q2.size()), 0);
        chk("q4_empty", 32'(q4.size()), 0);
        chk("d4_ovf", 32'(ovf4), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
